// File: rtl/cmp_share_arbiter.sv
// rtl/cmp_share_arbiter.sv - shared increment/compare/saturate unit arbitrated among NREQ requesters
//
// Purpose: arbitrates among NREQ requesters, captures the winner's operands,
// runs a single compare (a+1 vs b, saturate on all-ones) and returns a tagged
// result. Only one operation is in flight: IDLE -> EXEC -> RESP -> IDLE.
//
// Build option: define CMP_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins); otherwise round-robin starting after the last granted requester.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req         per-requester request level, sampled only in IDLE
//   op_a, op_b  packed operands, requester i at [i*W +: W]
//   ack         one-hot pulse in EXEC: that requester's operands were captured
//   resp_valid  one-cycle pulse in RESP qualifying resp_id/resp_flag/resp_ret
//   resp_id     requester index of the result (held between responses)
//   resp_flag   compare result (held)
//   resp_ret    all-ones when resp_flag, else zero (held)
//   busy        high whenever the FSM is not in IDLE
module cmp_share_arbiter #(
    parameter int  NREQ = 4,
    parameter int  W    = 2,
    localparam int IDW  = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   ack,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_flag,
    output logic [W-1:0]      resp_ret,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  win_q, win_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic            resp_flag_q, resp_flag_d;
    logic [W-1:0]    resp_ret_q, resp_ret_d;
    logic            busy_q, busy_d;

    logic            grant_valid;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [W-1:0]    a_inc;
    logic            cmp_flag;

`ifdef CMP_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest active index is the last one written.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        sel_a       = '0;
        sel_b       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(i);
                grant_oh    = NREQ'(1) << i;
                sel_a       = op_a[i*W +: W];
                sel_b       = op_b[i*W +: W];
            end
        end
    end
`else
    logic [IDW-1:0] last_q, last_d;

    // Round-robin in two passes: first the lowest active index above the
    // last grant, then wrap around to the lowest active index at or below it.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        sel_a       = '0;
        sel_b       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_valid && req[i] && (i > int'(last_q))) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(i);
                grant_oh    = NREQ'(1) << i;
                sel_a       = op_a[i*W +: W];
                sel_b       = op_b[i*W +: W];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_valid && req[i] && (i <= int'(last_q))) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(i);
                grant_oh    = NREQ'(1) << i;
                sel_a       = op_a[i*W +: W];
                sel_b       = op_b[i*W +: W];
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && grant_valid) begin
            last_d = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Increment wraps modulo 2^W; an all-ones increment result saturates.
    assign a_inc    = a_q + W'(1);
    assign cmp_flag = (a_inc > b_q) || (a_inc == {W{1'b1}});

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        a_d          = a_q;
        b_d          = b_q;
        ack_d        = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_flag_d  = resp_flag_q;
        resp_ret_d   = resp_ret_q;
        busy_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = EXEC;
                    win_d   = grant_idx;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    ack_d   = grant_oh;
                    busy_d  = 1'b1;
                end
            end
            EXEC: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_id_d    = win_q;
                resp_flag_d  = cmp_flag;
                resp_ret_d   = cmp_flag ? {W{1'b1}} : '0;
                busy_d       = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            win_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            ack_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_flag_q  <= 1'b0;
            resp_ret_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ack_q        <= ack_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_flag_q  <= resp_flag_d;
            resp_ret_q   <= resp_ret_d;
            busy_q       <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_flag  = resp_flag_q;
    assign resp_ret   = resp_ret_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb/tb_cmp_share_arbiter.sv - scoreboard testbench for cmp_share_arbiter
module tb_cmp_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 2;
    localparam int IDW  = 2;
    localparam int AW   = NREQ * W;
    localparam int MAXV = (1 << W) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [AW-1:0]   op_a = '0;
    logic [AW-1:0]   op_b = '0;
    logic [NREQ-1:0] ack;
    logic            resp_valid;
    logic [IDW-1:0]  resp_id;
    logic            resp_flag;
    logic [W-1:0]    resp_ret;
    logic            busy;

    cmp_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .ack        (ack),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_flag  (resp_flag),
        .resp_ret   (resp_ret),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ack_vec;
    } ack_exp_t;

    typedef struct {
        int cyc;
        int id;
        int flag;
        int ret;
    } resp_exp_t;

    ack_exp_t  ack_q[$];
    resp_exp_t resp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_last   = NREQ - 1;
    int m_hold   = 0;
    int exp_busy = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an accepted request occupies the unit for three
    // cycles; results follow from the arithmetic definition of the compare.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n) begin
                if (m_hold > 0) begin
                    m_hold--;
                end else if (req != '0) begin
                    int w;
                    int a;
                    int b;
                    int ai;
                    int f;
                    w = -1;
`ifdef CMP_ARB_FIXED_PRIO_EN
                    for (int k = 0; k < NREQ; k++) begin
                        if (w < 0 && req[k]) w = k;
                    end
`else
                    for (int k = 1; k <= NREQ; k++) begin
                        int c;
                        c = (m_last + k) % NREQ;
                        if (w < 0 && req[c]) w = c;
                    end
                    m_last = w;
`endif
                    a  = int'(op_a[w*W +: W]);
                    b  = int'(op_b[w*W +: W]);
                    ai = (a + 1) % (MAXV + 1);
                    f  = (ai > b || ai == MAXV) ? 1 : 0;
                    ack_q.push_back('{cyc, 1 << w});
                    resp_q.push_back('{cyc + 1, w, f, f ? MAXV : 0});
                    m_hold = 2;
                end
            end
            exp_busy = (m_hold > 0) ? 1 : 0;
        end
    end

    // A reset discards whatever is in flight and restarts arbitration.
    always @(negedge rst_n) begin
        ack_q.delete();
        resp_q.delete();
        m_hold   = 0;
        m_last   = NREQ - 1;
        exp_busy = 0;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_ack", int'(ack), 0);
                check("rst_resp_valid", int'(resp_valid), 0);
                check("rst_resp_id", int'(resp_id), 0);
                check("rst_resp_flag", int'(resp_flag), 0);
                check("rst_resp_ret", int'(resp_ret), 0);
                check("rst_busy", int'(busy), 0);
            end else begin
                check("busy", int'(busy), exp_busy);
                if (ack != '0) begin
                    if (ack_q.size() == 0) begin
                        check("ack_unexpected", int'(ack), 0);
                    end else begin
                        ack_exp_t e;
                        e = ack_q.pop_front();
                        check("ack_vec", int'(ack), e.ack_vec);
                        check("ack_cycle", cyc, e.cyc);
                    end
                end
                if (resp_valid) begin
                    if (resp_q.size() == 0) begin
                        check("resp_unexpected", 1, 0);
                    end else begin
                        resp_exp_t r;
                        r = resp_q.pop_front();
                        check("resp_cycle", cyc, r.cyc);
                        check("resp_id", int'(resp_id), r.id);
                        check("resp_flag", int'(resp_flag), r.flag);
                        check("resp_ret", int'(resp_ret), r.ret);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [NREQ-1:0] r, input logic [AW-1:0] a, input logic [AW-1:0] b);
        @(negedge clk);
        req  = r;
        op_a = a;
        op_b = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, op_a, op_b);
    endtask

    initial begin
        // Reset held while inputs toggle.
        for (int i = 0; i < 6; i++) begin
            drive(NREQ'($urandom), AW'($urandom), AW'($urandom));
        end
        drive('0, '0, '0);
        #1 rst_n = 1'b1;
        idle(2);

        // Saturate: a0=2, b0=3.
        drive(4'b0001, 8'h02, 8'h03);
        idle(3);
        // Wrap: a2=3, b2=0.
        drive(4'b0100, 8'h30, 8'h00);
        idle(3);
        // a2=1, b2=1.
        drive(4'b0100, 8'h10, 8'h10);
        idle(3);

        // All requesting continuously.
        for (int i = 0; i < 15; i++) begin
            drive(4'b1111, AW'($urandom), AW'($urandom));
        end
        idle(3);

        // Operand change in the ack cycle must not affect the result.
        drive(4'b0010, 8'h00, 8'h04);
        drive(4'b0000, 8'h0C, 8'h04);
        idle(3);

        // Reset during EXEC: grant to 1, then reset, then 0 and 2 compete.
        drive(4'b0010, 8'h55, 8'hAA);
        drive(4'b0000, 8'h55, 8'hAA);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        drive(4'b0101, AW'($urandom), AW'($urandom));
        idle(4);

        // Fixed-priority style contention: 0 and 2 held continuously.
        for (int i = 0; i < 12; i++) begin
            drive(4'b0101, AW'($urandom), AW'($urandom));
        end
        idle(3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) drive('0, AW'($urandom), AW'($urandom));
            else drive(NREQ'($urandom), AW'($urandom), AW'($urandom));
        end
        idle(6);

        check("ack_queue_drained", ack_q.size(), 0);
        check("resp_queue_drained", resp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
